// File: rtl/mult_control.sv
// Sequential shift-add controller for a 32x32 unsigned multiplier, with the mult_alu step inlined.
// Optional feature: define MULT_ZERO_SKIP_EN to bypass RUN when either operand is zero.
module mult_control #(
  parameter int unsigned N_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        range_err
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_d;
  logic [W-1:0]   prod, prod_d;
  logic [W-1:0]   mplr, mplr_d;
  logic [W-1:0]   mcand, mcand_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           busy_d, done_d, range_err_d;
  logic [W-1:0]   result_hi_d, result_lo_d;

  logic           alu_sign;
  logic [W-1:0]   sum;
  logic [W-1:0]   product_res;
  logic [W-1:0]   multipliar_res;
  logic           zero_op;

  // One ALU step: conditional add (carry-out dropped), then shift {hi,lo} right by one.
  always_comb begin
    alu_sign       = mplr[0];
    sum            = alu_sign ? W'(prod + mcand) : prod;
    product_res    = {1'b0, sum[W-1:1]};
    multipliar_res = {sum[0], mplr[W-1:1]};
  end

`ifdef MULT_ZERO_SKIP_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    prod_d      = prod;
    mplr_d      = mplr;
    mcand_d     = mcand;
    cnt_d       = cnt;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    result_hi_d = result_hi;
    result_lo_d = result_lo;
    range_err_d = range_err;

    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          prod_d  = '0;
          mplr_d  = multiplier;
          mcand_d = multiplicand;
          cnt_d   = '0;
          if (zero_op) begin
            state_d     = DONE;
            done_d      = 1'b1;
            result_hi_d = '0;
            result_lo_d = '0;
            range_err_d = 1'b0;
          end else begin
            state_d     = RUN;
            busy_d      = 1'b1;
            range_err_d = multiplicand[W-1];
          end
        end
      end
      RUN: begin
        prod_d = product_res;
        mplr_d = multipliar_res;
        cnt_d  = cnt + CW'(1);
        if (cnt == CW'(N_STEPS - 1)) begin
          // Results load on the final step so they are valid with done.
          state_d     = DONE;
          done_d      = 1'b1;
          result_hi_d = product_res;
          result_lo_d = multipliar_res;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prod      <= '0;
      mplr      <= '0;
      mcand     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      range_err <= 1'b0;
    end else begin
      state     <= state_d;
      prod      <= prod_d;
      mplr      <= mplr_d;
      mcand     <= mcand_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      result_hi <= result_hi_d;
      result_lo <= result_lo_d;
      range_err <= range_err_d;
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// Directed self-checking bench for mult_control; expected products computed by hand.
// Honours MULT_ZERO_SKIP_EN when choosing the zero-operand latency.
module tb_mult_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  mult_control dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .result_hi    (result_hi),
    .result_lo    (result_lo),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a multiply, wait (bounded) for done, then check latency and results.
  // exp_lat counts rising edges after the accepting edge; 32 means done in cycle k+33.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic eerr, input bit repulse);
    int lat;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'(exp_lat != 0));
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (repulse && lat == 9) begin
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " latency"},   64'(lat),       64'(exp_lat));
    check({tag, " result_hi"}, 64'(result_hi), 64'(ehi));
    check({tag, " result_lo"}, 64'(result_lo), 64'(elo));
    check({tag, " range_err"}, 64'(range_err), 64'(eerr));
    check({tag, " busy_at_done"}, 64'(busy),   64'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done),     64'd0);
    check({tag, " hi_held"},    64'(result_hi), 64'(ehi));
    check({tag, " lo_held"},    64'(result_lo), 64'(elo));
  endtask

  initial begin
    int zero_lat;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    check("reset busy",      64'(busy),      64'd0);
    check("reset done",      64'(done),      64'd0);
    check("reset result_hi", 64'(result_hi), 64'd0);
    check("reset result_lo", 64'(result_lo), 64'd0);
    check("reset range_err", 64'(range_err), 64'd0);
    rst = 1'b0;

    run_mult("t1_3x5",    32'd3,         32'd5,         32, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b0);
    run_mult("t2_ffff2",  32'h0000_FFFF, 32'h0000_FFFF, 32, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 1'b0);
    run_mult("t3_big",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 32, 32'h7FFF_FFFE, 32'h8000_0001, 1'b0, 1'b0);
    run_mult("t4_rerr",   32'h8000_0000, 32'd2,         32, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    run_mult("t4_repulse",32'h8000_0000, 32'd2,         32, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);

    // Reset mid-RUN discards the operation and clears results.
    @(negedge clk);
    multiplicand = 32'd11;
    multiplier   = 32'd13;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("t5 busy_mid_run", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5 rst busy",      64'(busy),      64'd0);
    check("t5 rst done",      64'(done),      64'd0);
    check("t5 rst result_hi", 64'(result_hi), 64'd0);
    check("t5 rst result_lo", 64'(result_lo), 64'd0);
    check("t5 rst range_err", 64'(range_err), 64'd0);
    rst = 1'b0;
    run_mult("t5_after", 32'd7, 32'd9, 32, 32'h0, 32'd63, 1'b0, 1'b0);

`ifdef MULT_ZERO_SKIP_EN
    zero_lat = 0;
`else
    zero_lat = 32;
`endif
    // Non-zero results first so the zero result is observable.
    run_mult("t6_pre",  32'h1234_5678, 32'h10, 32, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0);
    run_mult("t6_zero", 32'd0, 32'h1234, zero_lat, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
